// File: rtl/alu4.sv
// Registered 16-operation 4-bit ALU with one-cycle latency and a result-valid flag.
// Optional zero/carry flag outputs are built when ALU_FLAGS_EN is defined.
module alu4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             carry,
`endif
  output logic [WIDTH-1:0] res,
  output logic             ack
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3,
    OP_MOD  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
    OP_NAND = 4'h8, OP_NOR  = 4'h9, OP_XNOR = 4'hA, OP_NOT  = 4'hB,
    OP_SHL  = 4'hC, OP_SHR  = 4'hD, OP_ROL  = 4'hE, OP_GT   = 4'hF
  } op_e;

  logic [WIDTH-1:0] r_res, w_res;
  logic             r_ack, w_ack;
  logic             w_bz;

  assign w_bz = (b == '0);

  always_comb begin
    w_res = '0;
    w_ack = 1'b1;
    unique case (op_e'(s))
      OP_ADD:  w_res = a + b;
      OP_SUB:  w_res = a - b;
      OP_MUL:  w_res = a * b;
      OP_DIV: begin
        // Divide by zero saturates to all ones and withholds ack.
        w_res = w_bz ? '1 : a / b;
        w_ack = !w_bz;
      end
      OP_MOD: begin
        w_res = w_bz ? a : a % b;
        w_ack = !w_bz;
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_NOT:  w_res = ~a;
      OP_SHL:  w_res = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  w_res = {1'b0, a[WIDTH-1:1]};
      OP_ROL:  w_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_GT:   w_res = (a > b) ? WIDTH'(1) : '0;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res <= '0;
      r_ack <= 1'b0;
    end else begin
      r_res <= w_res;
      r_ack <= w_ack;
    end
  end

  assign res = r_res;
  assign ack = r_ack;

`ifdef ALU_FLAGS_EN
  logic w_carry;
  logic r_zero, r_carry;

  always_comb begin
    w_carry = 1'b0;
    case (op_e'(s))
      OP_ADD:         w_carry = ((WIDTH+1)'(a) + (WIDTH+1)'(b)) > (WIDTH+1)'(2**WIDTH - 1);
      OP_SUB:         w_carry = (a < b);
      OP_MUL:         w_carry = ((2*WIDTH)'(a) * (2*WIDTH)'(b)) > (2*WIDTH)'(2**WIDTH - 1);
      OP_SHL, OP_ROL: w_carry = a[WIDTH-1];
      OP_SHR:         w_carry = a[0];
      default:        w_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_zero  <= (w_res == '0);
      r_carry <= w_carry;
    end
  end

  assign zero  = r_zero;
  assign carry = r_carry;
`endif

endmodule

// File: tb/tb_alu4.sv
// Scoreboard bench for alu4: the driver queues hand-computed results, the monitor checks each edge.
module tb_alu4;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, s;
  logic [3:0] res;
  logic       ack;
`ifdef ALU_FLAGS_EN
  logic       zero, carry;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [3:0] res;
    logic       ack;
    logic       z;
    logic       c;
  } exp_t;

  exp_t q[$];

  alu4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s),
`ifdef ALU_FLAGS_EN
    .zero(zero), .carry(carry),
`endif
    .res(res), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic issue(input string nm, input logic r, input logic [3:0] ia, ib, is,
                       input logic [3:0] er, input logic ea, ez, ec);
    exp_t e;
    @(negedge clk);
    rst = r; a = ia; b = ib; s = is;
    e.name = nm; e.res = er; e.ack = ea; e.z = ez; e.c = ec;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (res !== e.res) begin
        errors++;
        $display("FAIL %s res: got %b want %b", e.name, res, e.res);
      end
      checks++;
      if (ack !== e.ack) begin
        errors++;
        $display("FAIL %s ack: got %b want %b", e.name, ack, e.ack);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (zero !== e.z) begin
        errors++;
        $display("FAIL %s zero: got %b want %b", e.name, zero, e.z);
      end
      checks++;
      if (carry !== e.c) begin
        errors++;
        $display("FAIL %s carry: got %b want %b", e.name, carry, e.c);
      end
`endif
    end
  end

  initial begin
    rst = 1'b1; a = 4'h0; b = 4'h0; s = 4'h0;
    // reset with arbitrary inputs
    issue("rst0", 1, 4'hF, 4'h1, 4'h0, 4'h0, 0, 0, 0);
    issue("rst1", 1, 4'h7, 4'h3, 4'h2, 4'h0, 0, 0, 0);
    // sweep a=0100 b=0010
    issue("add",  0, 4'h4, 4'h2, 4'h0, 4'b0110, 1, 0, 0);
    issue("sub",  0, 4'h4, 4'h2, 4'h1, 4'b0010, 1, 0, 0);
    issue("mul",  0, 4'h4, 4'h2, 4'h2, 4'b1000, 1, 0, 0);
    issue("div",  0, 4'h4, 4'h2, 4'h3, 4'b0010, 1, 0, 0);
    issue("mod",  0, 4'h4, 4'h2, 4'h4, 4'b0000, 1, 1, 0);
    issue("and",  0, 4'h4, 4'h2, 4'h5, 4'b0000, 1, 1, 0);
    issue("or",   0, 4'h4, 4'h2, 4'h6, 4'b0110, 1, 0, 0);
    issue("xor",  0, 4'h4, 4'h2, 4'h7, 4'b0110, 1, 0, 0);
    issue("nand", 0, 4'h4, 4'h2, 4'h8, 4'b1111, 1, 0, 0);
    issue("nor",  0, 4'h4, 4'h2, 4'h9, 4'b1001, 1, 0, 0);
    issue("xnor", 0, 4'h4, 4'h2, 4'hA, 4'b1001, 1, 0, 0);
    issue("not",  0, 4'h4, 4'h2, 4'hB, 4'b1011, 1, 0, 0);
    issue("shl",  0, 4'h4, 4'h2, 4'hC, 4'b1000, 1, 0, 0);
    issue("shr",  0, 4'h4, 4'h2, 4'hD, 4'b0010, 1, 0, 0);
    issue("rol",  0, 4'h4, 4'h2, 4'hE, 4'b1000, 1, 0, 0);
    issue("gt",   0, 4'h4, 4'h2, 4'hF, 4'b0001, 1, 0, 0);
    // wrap and overflow
    issue("subwrap", 0, 4'b0010, 4'b0100, 4'h1, 4'b1110, 1, 0, 1);
    issue("mulovf",  0, 4'b0100, 4'b1000, 4'h2, 4'b0000, 1, 1, 1);
    issue("addovf",  0, 4'b1111, 4'b0001, 4'h0, 4'b0000, 1, 1, 1);
    // divide by zero, then recovery
    issue("div0",  0, 4'b1001, 4'b0000, 4'h3, 4'b1111, 0, 0, 0);
    issue("mod0",  0, 4'b1001, 4'b0000, 4'h4, 4'b1001, 0, 0, 0);
    issue("div3",  0, 4'b1001, 4'b0011, 4'h3, 4'b0011, 1, 0, 0);
    // reset mid-stream
    issue("addpre", 0, 4'b0101, 4'b0011, 4'h0, 4'b1000, 1, 0, 0);
    issue("rstmid", 1, 4'b0101, 4'b0011, 4'h0, 4'b0000, 0, 0, 0);
    issue("gteq",   0, 4'b0011, 4'b0011, 4'hF, 4'b0000, 1, 1, 0);
    // rotate / shift boundaries
    issue("rol9",  0, 4'b1001, 4'b0000, 4'hE, 4'b0011, 1, 0, 1);
    issue("shr9",  0, 4'b1001, 4'b0000, 4'hD, 4'b0100, 1, 0, 1);
    issue("shl9",  0, 4'b1001, 4'b0000, 4'hC, 4'b0010, 1, 0, 1);
    issue("gtlt",  0, 4'b0010, 4'b0111, 4'hF, 4'b0000, 1, 1, 0);
    // drain with bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu4.md
Name: alu4

Overview:
- Registered 4-bit, 16-operation arithmetic/logic unit.
- The 4-bit selector `s` picks the operation on operands `a` and `b`.
- The result is captured on the rising clock edge; `ack` flags a valid result.
- Sits as a leaf datapath block beside control logic that drives `s` every cycle.

Parameters:
- WIDTH, 4, operand and result width. All behaviour below is defined for 4; other values are not supported.

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  reset, synchronous, active-high
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- s  input  4  operation select
- res  output  4  registered result
- ack  output  1  registered result-valid flag

Behaviour:
- One clock; reset is synchronous and active-high. While rst=1 at a rising edge: res<=0000, ack<=0.
- Otherwise, each rising edge samples a, b, s and loads res with op(s,a,b). Latency is 1 cycle and a new op is accepted every cycle. No handshake input.
- ack<=1 on every non-reset edge, except for divide/modulo by zero, where ack<=0.
- All arithmetic is unsigned modulo 16; only the low 4 bits are kept.
- Operation encoding:
  - 0000 ADD: a+b
  - 0001 SUB: a-b, wraps (2-4 = 1110)
  - 0010 MUL: low nibble of a*b
  - 0011 DIV: a/b truncated; b=0 gives res=1111, ack=0
  - 0100 MOD: a%b; b=0 gives res=a, ack=0
  - 0101 AND: a&b
  - 0110 OR: a|b
  - 0111 XOR: a^b
  - 1000 NAND: ~(a&b)
  - 1001 NOR: ~(a|b)
  - 1010 XNOR: ~(a^b)
  - 1011 NOT: ~a (b ignored)
  - 1100 SHL: a<<1, zero fill
  - 1101 SHR: a>>1, zero fill
  - 1110 ROL: {a[2:0],a[3]}
  - 1111 GT: 0001 if a>b, else 0000
- s, a and b changing every cycle is legal; each edge uses only the values sampled at that edge.
- Reset mid-stream: the next edge with rst=1 clears res and ack. The first edge after rst falls produces a valid result with ack=1.
- No X propagation required; all 16 codes are defined.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, adds two registered 1-bit outputs, updated on the same edge as res and cleared to 0 by reset:
  - zero: 1 when the 4-bit result is 0000.
  - carry:
    - ADD: carry-out of a+b.
    - SUB: borrow (a<b).
    - MUL: product > 15.
    - SHL and ROL: a[3].
    - SHR: a[0].
    - All other ops: 0.
- When undefined, these ports and their logic are absent; res and ack behaviour is identical either way.

Test Plan:
- Reset: hold rst=1 for 2 edges with any inputs -> res=0000, ack=0. Release rst -> the next edge gives ack=1.
- Full sweep with a=0100, b=0010, stepping s from 0000 to 1111 one per cycle, checked one cycle later:
  - 0000–0100: 0110, 0010, 1000, 0010, 0000
  - 0101–1010: 0000, 0110, 0110, 1111, 1001, 1001
  - 1011–1111: 1011, 1000, 0010, 1000, 0001
  - ack=1 throughout.
- Wrap and overflow:
  - a=0010, b=0100, s=0001 -> res=1110.
  - a=0100, b=1000, s=0010 -> res=0000.
  - a=1111, b=0001, s=0000 -> res=0000. With ALU_FLAGS_EN: carry=1, zero=1.
- Divide by zero with a=1001, b=0000:
  - s=0011 -> res=1111, ack=0.
  - s=0100 -> res=1001, ack=0.
  - Then b=0011, s=0011 -> res=0011, ack=1.
- Reset mid-stream: issue ADD 0101+0011, assert rst on the following edge -> res=0000, ack=0. Deassert -> the next op result appears with ack=1.
- Compare/rotate:
  - a=0011, b=0011, s=1111 -> 0000.
  - a=1001, s=1110 -> 0011.
  - a=1001, s=1101 -> 0100.
